proc_imul_arbiter: RTL
======================

Name: proc_imul_arbiter

Overview:
- Shares one iterative integer multiplier (64-bit operand-pair request, 32-bit product response, val/rdy on both sides) among p_num_reqs requesters, e.g. the X stages of several cores.
- Round-robin grant.
- At most one multiply is in flight at a time.
- The response is routed back only to the requester that owns the in-flight operation.

Parameters:
p_num_reqs, 2, number of requesters; legal range 2..8
c_id_nbits, $clog2(p_num_reqs), derived localparam; width of the owner id

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
req_val  input  p_num_reqs  per-requester request valid
req_rdy  output  p_num_reqs  per-requester request ready
req_msg  input  64*p_num_reqs  per-requester {op1,op2}; requester i occupies bits [64*i+63:64*i]
resp_val  output  p_num_reqs  per-requester response valid
resp_rdy  input  p_num_reqs  per-requester response ready
resp_msg  output  32  product, broadcast to all requesters
imul_req_val  output  1  multiplier request valid
imul_req_rdy  input  1  multiplier request ready
imul_req_msg  output  64  operand pair forwarded from the granted requester
imul_resp_val  input  1  multiplier response valid
imul_resp_rdy  output  1  multiplier response ready
busy  output  1  1 while an operation is owned (state WAIT)
owner  output  c_id_nbits  id of the current or last granted requester

Behaviour:
- State registers:
  - state: IDLE or WAIT
  - prio_ptr: c_id_nbits, the highest-priority requester
  - owner_reg: c_id_nbits
- Reset (reset==0 at a rising edge):
  - state=IDLE, prio_ptr=0, owner_reg=0.
  - While reset==0, all outputs are forced low: req_rdy, resp_val, imul_req_val, imul_resp_rdy, busy.
  - resp_msg, imul_req_msg and owner still follow their normal assignments.
- Grant (combinational, IDLE only):
  - Scan req_val starting at index prio_ptr, then ascending with wrap (prio_ptr, prio_ptr+1, ..., p_num_reqs-1, 0, ...).
  - The first asserted index is grant_id, with a one-hot grant.
- IDLE outputs:
  - imul_req_val = |req_val.
  - imul_req_msg = slice grant_id of req_msg; 0 when no request.
  - req_rdy = grant one-hot & {p_num_reqs{imul_req_rdy}}.
  - Non-granted requesters see rdy=0 even if the multiplier is ready.
- IDLE -> WAIT when imul_req_val && imul_req_rdy:
  - owner_reg <= grant_id.
  - prio_ptr <= grant_id+1, wrapping to 0 when grant_id==p_num_reqs-1.
- WAIT outputs:
  - All req_rdy=0 and imul_req_val=0.
  - resp_val = one-hot(owner_reg) & imul_resp_val.
  - imul_resp_rdy = resp_rdy[owner_reg]; resp_rdy of non-owners is ignored.
- WAIT -> IDLE when imul_resp_val && imul_resp_rdy.
  - The next grant can fire no earlier than the following cycle, so there is one bubble cycle between operations.
- Combinational paths and outputs:
  - resp_msg = imul_resp_msg combinationally in all states.
  - busy = (state==WAIT).
  - owner = owner_reg.
- No buffering. The arbiter adds zero latency on the request path and zero latency on the response path; total latency is the multiplier latency.
- Requester contract:
  - req_msg is held stable while req_val=1 and req_rdy=0.
  - A requester may drop req_val before being granted; prio_ptr is unchanged in that case.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,...,N-1,0,...
  - A requester waits at most N-1 operations.
- Sanity check: imul_resp_val in IDLE is a protocol error. imul_resp_rdy=0 in IDLE, so the response is not consumed; the bench flags it.
- Reset mid-operation: state returns to IDLE and ownership is lost. The multiplier shares the same reset, so no stale response is delivered.

Test Plan:
- Single request: reset, then req_val=2'b01 with op1=7, op2=6 -> req_rdy[0]=1 in the same cycle; busy=1 next cycle; later resp_val=2'b01, resp_msg=42; busy=0 one cycle after resp fire.
- Round robin: both valid continuously with req 0=3*5 and req 1=4*4 -> grants 0,1,0,1; owner sequence 0,1,0,1; resp 15 to 0 then 16 to 1, each on its own resp_val bit.
- Response backpressure: owner=1, resp_rdy[1]=0 for 5 cycles while resp_rdy[0]=1 -> imul_resp_rdy=0, resp_val=2'b10 held, no IDLE transition; the response fires when resp_rdy[1] rises.
- Multiplier not ready: imul_req_rdy=0 with req_val=2'b11 -> req_rdy=0, state stays IDLE, prio_ptr unchanged; on imul_req_rdy=1, requester prio_ptr is granted.
- Wrap, with p_num_reqs=4: prio_ptr=3 and req_val=4'b1001 -> requester 3 granted, prio_ptr becomes 0; next grant goes to requester 0.
- Reset mid-op: reset=0 during WAIT for one edge -> busy=0, owner=0, all req_rdy/resp_val low while reset=0; a fresh request after reset completes correctly (9*9=81).

Source files
------------

// File: rtl/proc_imul_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : proc_imul_arbiter_if
//  Purpose  : Handshake bundle between N requesters, the multiplier arbiter
//             and one shared iterative integer multiplier.
//  Signals  : req_val/req_rdy/req_msg      - per-requester request channel
//             resp_val/resp_rdy/resp_msg   - per-requester response channel
//             imul_req_*                   - request channel to multiplier
//             imul_resp_*                  - response channel from multiplier
//             busy, owner                  - arbiter status
//  Modports : slave  - arbiter view
//             master - environment view (requesters + multiplier)
//  Revision : 1.0  initial release
// ============================================================================
interface proc_imul_arbiter_if #(
    parameter int P_NUM_REQS = 2
);
    localparam int C_ID_NBITS = $clog2(P_NUM_REQS);

    logic [P_NUM_REQS-1:0]    req_val;
    logic [P_NUM_REQS-1:0]    req_rdy;
    logic [64*P_NUM_REQS-1:0] req_msg;
    logic [P_NUM_REQS-1:0]    resp_val;
    logic [P_NUM_REQS-1:0]    resp_rdy;
    logic [31:0]              resp_msg;
    logic                     imul_req_val;
    logic                     imul_req_rdy;
    logic [63:0]              imul_req_msg;
    logic                     imul_resp_val;
    logic                     imul_resp_rdy;
    logic [31:0]              imul_resp_msg;
    logic                     busy;
    logic [C_ID_NBITS-1:0]    owner;

    modport slave (
        input  req_val, req_msg, resp_rdy, imul_req_rdy, imul_resp_val, imul_resp_msg,
        output req_rdy, resp_val, resp_msg, imul_req_val, imul_req_msg, imul_resp_rdy,
               busy, owner
    );

    modport master (
        output req_val, req_msg, resp_rdy, imul_req_rdy, imul_resp_val, imul_resp_msg,
        input  req_rdy, resp_val, resp_msg, imul_req_val, imul_req_msg, imul_resp_rdy,
               busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/proc_imul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : proc_imul_arbiter
//  Purpose  : Round-robin arbiter sharing one iterative multiplier among
//             P_NUM_REQS requesters. One operation in flight at a time; the
//             response is steered back to the requester that owns it.
//  Ports    : clk   - clock, rising edge
//             reset - synchronous reset, active low
//             bus   - proc_imul_arbiter_if.slave (request/response channels,
//                     multiplier channels, busy/owner status)
//  Revision : 1.0  initial release
// ============================================================================
module proc_imul_arbiter #(
    parameter int P_NUM_REQS = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    proc_imul_arbiter_if.slave  bus
);
    localparam int C_ID_NBITS = $clog2(P_NUM_REQS);
    localparam int C_IDX_W    = C_ID_NBITS + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [C_ID_NBITS-1:0]   r_prio_ptr;
    logic [C_ID_NBITS-1:0]   w_prio_nxt;
    logic [C_ID_NBITS-1:0]   r_owner;
    logic [C_ID_NBITS-1:0]   w_owner_nxt;

    logic [C_ID_NBITS-1:0]   w_grant_id;
    logic                    w_found;
    logic [C_IDX_W-1:0]      w_idx;
    logic [P_NUM_REQS-1:0]   w_grant_oh;

    logic [P_NUM_REQS-1:0]   w_req_rdy;
    logic [P_NUM_REQS-1:0]   w_resp_val;
    logic                    w_imul_req_val;
    logic [63:0]             w_imul_req_msg;
    logic                    w_imul_resp_rdy;

    // Rotating priority scan: visit prio_ptr, prio_ptr+1, ... with wrap and
    // take the first asserted request. The index is one bit wider than the
    // id so the sum cannot overflow before the wrap correction.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_idx      = '0;
        for (int k = 0; k < P_NUM_REQS; k++) begin
            w_idx = {1'b0, r_prio_ptr} + C_IDX_W'(k);
            if (w_idx >= C_IDX_W'(P_NUM_REQS)) begin
                w_idx = w_idx - C_IDX_W'(P_NUM_REQS);
            end
            if (!w_found && bus.req_val[w_idx[C_ID_NBITS-1:0]]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx[C_ID_NBITS-1:0];
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        if (w_found) begin
            w_grant_oh[w_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_prio_ptr <= '0;
            r_owner    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio_ptr <= w_prio_nxt;
            r_owner    <= w_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_prio_nxt      = r_prio_ptr;
        w_owner_nxt     = r_owner;
        w_req_rdy       = '0;
        w_resp_val      = '0;
        w_imul_req_val  = 1'b0;
        w_imul_req_msg  = '0;
        w_imul_resp_rdy = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_imul_req_val = w_found;
                if (w_found) begin
                    w_imul_req_msg = bus.req_msg[w_grant_id*64 +: 64];
                end
                // Only the granted requester may see ready, so a losing
                // requester never believes its operands were taken.
                w_req_rdy = w_grant_oh & {P_NUM_REQS{bus.imul_req_rdy}};
                if (w_found && bus.imul_req_rdy) begin
                    w_state_nxt = ST_WAIT;
                    w_owner_nxt = w_grant_id;
                    w_prio_nxt  = (w_grant_id == C_ID_NBITS'(P_NUM_REQS - 1))
                                  ? '0 : w_grant_id + 1'b1;
                end
            end
            ST_WAIT: begin
                w_resp_val[r_owner] = bus.imul_resp_val;
                w_imul_resp_rdy     = bus.resp_rdy[r_owner];
                if (bus.imul_resp_val && bus.resp_rdy[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Handshake outputs stay quiet while reset is held so neither side
        // can complete a transfer that the next edge would discard.
        if (!reset) begin
            w_req_rdy       = '0;
            w_resp_val      = '0;
            w_imul_req_val  = 1'b0;
            w_imul_resp_rdy = 1'b0;
        end
    end

    assign bus.req_rdy       = w_req_rdy;
    assign bus.resp_val      = w_resp_val;
    assign bus.imul_req_val  = w_imul_req_val;
    assign bus.imul_req_msg  = w_imul_req_msg;
    assign bus.imul_resp_rdy = w_imul_resp_rdy;
    assign bus.resp_msg      = bus.imul_resp_msg;
    assign bus.busy          = (r_state == ST_WAIT) && reset;
    assign bus.owner         = r_owner;

endmodule
`default_nettype wire
